bbs_mod_reduce: RTL and testbench

Sequential modular reducer that sits directly downstream of the 128-bit squaring pipeline in the BBS generator. Computes `remainder = product mod modulus` for a 256-bit square and a 128-bit modulus. Uses restoring shift-subtract, one bit per cycle, or two bits per cycle when compiled for radix-4. The result feeds back as the next BBS state `x(i+1) = x(i)^2 mod M`, and its LSB is the generator output bit.

---
 rtl/bbs_mod_reduce.sv | 84 ++++++++
 tb/tb_bbs_mod_reduce.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bbs_mod_reduce.sv
// bbs_mod_reduce: restoring shift-subtract product mod modulus; define BBS_MOD_RADIX4_EN for two bits per cycle
module bbs_mod_reduce #(
  parameter int PW = 256,
  parameter int MW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] product,
  input  logic [MW-1:0] modulus,
  output logic [MW-1:0] remainder,
  output logic          done,
  output logic          busy,
  output logic          err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
`ifdef BBS_MOD_RADIX4_EN
  localparam int ST = 2;
`else
  localparam int ST = 1;
`endif
  localparam int CW = $clog2(PW + 1);
  logic [0:0]    state;
  logic [PW-1:0] p;
  logic [MW:0]   r;
  logic [MW-1:0] m;
  logic [CW-1:0] cnt;
  logic [MW:0]   r_nxt;
  logic [PW-1:0] p_nxt;
  function automatic logic [MW:0] bit_step(input logic [MW:0] ri, input logic b, input logic [MW-1:0] mi);
    logic [MW:0] rs;
    rs = {ri[MW-1:0], b};
    return rs >= {1'b0, mi} ? rs - {1'b0, mi} : rs;
  endfunction
  // bit steps consumed this cycle, each with its own conditional subtract
  always_comb begin
`ifdef BBS_MOD_RADIX4_EN
    r_nxt = bit_step(bit_step(r, p[PW-1], m), p[PW-2], m);
`else
    r_nxt = bit_step(r, p[PW-1], m);
`endif
    p_nxt = p << ST;
  end
  assign busy = state == RUN;
  // accept in IDLE, iterate in RUN, publish the remainder on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      r         <= '0;
      m         <= '0;
      cnt       <= '0;
      remainder <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (start && modulus == '0) begin
          remainder <= '0;
          done      <= 1'b1;
          err       <= 1'b1;
        end else if (start) begin
          p     <= product;
          m     <= modulus;
          r     <= '0;
          cnt   <= CW'(PW);
          state <= RUN;
        end
      end else begin
        r   <= r_nxt;
        p   <= p_nxt;
        cnt <= cnt - CW'(ST);
        if (cnt == CW'(ST)) begin
          remainder <= r_nxt[MW-1:0];
          done      <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bbs_mod_reduce.sv
// tb_bbs_mod_reduce: directed and golden-model checks of the modular reducer
module tb_bbs_mod_reduce;
`ifdef BBS_MOD_RADIX4_EN
  localparam int N = 128;
`else
  localparam int N = 256;
`endif
  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic [255:0] product = '0;
  logic [127:0] modulus = '0;
  logic [127:0] remainder;
  logic         done, busy, err;
  int           checks = 0;
  int           errors = 0;

  bbs_mod_reduce dut (
    .clk(clk), .rst(rst), .start(start), .product(product), .modulus(modulus),
    .remainder(remainder), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(inout int n);
    int lim;
    lim = n + 2 * N + 20;
    while (n < lim) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic [255:0] pv, input logic [127:0] mv, input logic [127:0] exp);
    int n;
    @(negedge clk);
    start = 1; product = pv; modulus = mv;
    @(posedge clk); #1;
    start = 0; product = ~pv; modulus = ~mv;
    if (mv == '0) begin
      check({tag, " done"}, done, 1);
      check({tag, " err"}, err, 1);
      check({tag, " rem"}, remainder, 0);
      check({tag, " busy"}, busy, 0);
    end else begin
      check({tag, " busy"}, busy, 1);
      n = 0;
      wait_done(n);
      check({tag, " lat"}, n, N);
      check({tag, " rem"}, remainder, exp);
      check({tag, " err"}, err, 0);
      check({tag, " busy_end"}, busy, 0);
    end
    @(posedge clk); #1;
    check({tag, " pulse"}, {done, err}, 0);
  endtask

  initial begin
    logic [255:0] pr;
    logic [127:0] mr;
    int n, cnt_done;
    repeat (2) @(posedge clk);
    #1;
    check("rst rem", remainder, 0);
    check("rst flags", {done, busy, err}, 0);
    @(negedge clk) rst = 0;
    run("small", 256'd100, 128'd7, 128'd2);
    run("ones_m", '1, '1, 128'd0);
    run("ones_p", '1, {1'b1, 126'd0, 1'b1}, 128'd3);
    run("p_lt_m", 256'd5, 128'd9, 128'd5);
    run("m_one", {128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210}, 128'd1, 128'd0);
    run("small2", 256'd100, 128'd7, 128'd2);
    run("m_zero", 256'd12345, 128'd0, 128'd0);
    // start ignored mid-run, then back-to-back start in the done cycle
    @(negedge clk);
    start = 1; product = 256'd1000; modulus = 128'd13;
    @(posedge clk); #1;
    start = 0;
    repeat (49) @(posedge clk);
    #1;
    start = 1; product = 256'd999; modulus = 128'd5;
    @(posedge clk); #1;
    start = 0;
    n = 50;
    wait_done(n);
    check("mid lat", n, N);
    check("mid rem", remainder, 12);
    start = 1; product = 256'd100; modulus = 128'd7;
    @(posedge clk); #1;
    start = 0; n++;
    check("b2b busy", busy, 1);
    check("b2b done_low", done, 0);
    wait_done(n);
    check("b2b lat", n, 2 * N + 1);
    check("b2b rem", remainder, 2);
    // reset in the middle of a run
    @(negedge clk);
    start = 1; product = 256'd1000; modulus = 128'd13;
    @(posedge clk); #1;
    start = 0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rrst busy", busy, 0);
    check("rrst rem", remainder, 0);
    cnt_done = 0;
    repeat (N + 20) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    check("rrst no_done", cnt_done, 0);
    run("after_rst", 256'd1000, 128'd13, 128'd12);
    // golden-model vectors
    for (int i = 0; i < 30; i++) begin
      pr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mr = {$urandom, $urandom, $urandom, $urandom};
      if (i % 3 == 1) mr = mr >> $urandom_range(120, 1);
      if (mr == '0) mr = 128'd3;
      run("rand", pr, mr, 128'(pr % {128'd0, mr}));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
